// File: rtl/lc3b_types.sv
// Shared LC-3b core types.
//   lc3b_memseq_state_t : MEM-stage memory sequencer states
//   lc3b_mem_req_t      : one MEM-stage request at the default core widths
//   LC3B_MAX_IND        : indirection depth of the default core build
package lc3b_types;

  localparam int unsigned LC3B_ADDR_W  = 16;
  localparam int unsigned LC3B_DATA_W  = 16;
  localparam int unsigned LC3B_MAX_IND = 1;
  localparam int unsigned LC3B_IND_W   = $clog2(LC3B_MAX_IND + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PTR,
    S_FINAL,
    S_DONE
  } lc3b_memseq_state_t;

  typedef struct packed {
    logic                       is_store;
    logic [LC3B_IND_W-1:0]      ind;
    logic [LC3B_ADDR_W-1:0]     addr;
    logic [LC3B_DATA_W-1:0]     wdata;
    logic [LC3B_DATA_W/8-1:0]   wmask;
  } lc3b_mem_req_t;

endpackage

// File: rtl/mem_indirect_seq_req_reg.sv
// Request latch and indirection down-counter for mem_indirect_seq.
//   clk, rst_n      : clock, asynchronous active-low reset
//   load            : capture a new request (req_* inputs)
//   step            : a pointer read completed; follow next_ptr, decrement cnt
//   next_ptr        : pointer bits [ADDR_W-1:1] of the returned read data
//   is_store/cnt/addr/wdata/wmask : latched request state
module mem_req_reg #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned MAX_IND = 1,
  parameter int unsigned IND_W   = $clog2(MAX_IND + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic                step,
  input  logic                req_is_store,
  input  logic [IND_W-1:0]    req_ind,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_wmask,
  input  logic [ADDR_W-1:1]   next_ptr,
  output logic                is_store,
  output logic [IND_W-1:0]    cnt,
  output logic [ADDR_W-1:0]   addr,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wmask
);

  localparam logic [IND_W-1:0] CNT_MAX = IND_W'(MAX_IND);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      is_store <= 1'b0;
      cnt      <= '0;
      addr     <= '0;
      wdata    <= '0;
      wmask    <= '0;
    end else if (load) begin
      is_store <= req_is_store;
      cnt      <= (req_ind > CNT_MAX) ? CNT_MAX : req_ind;
      addr     <= req_addr;
      wdata    <= req_wdata;
      wmask    <= req_wmask;
    end else if (step) begin
      // Pointers are word-aligned: bit 0 of the fetched value is discarded.
      addr <= {next_ptr, 1'b0};
      cnt  <= cnt - IND_W'(1);
    end
  end

endmodule

// File: rtl/mem_indirect_seq.sv
// MEM-stage memory sequencer: runs 0..MAX_IND pointer reads, then a final
// load or byte-masked store, stalling the pipeline and pulsing done at the end.
//   req_*        : MEM-stage request, held stable while stall=1
//   stall, done  : pipeline freeze / one-cycle completion pulse
//   rdata        : final load data, held until the next load completes
//   dmem_*       : data-memory port (strobes held until dmem_resp)
module mem_indirect_seq
  import lc3b_types::*;
#(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned MAX_IND = LC3B_MAX_IND,
  parameter int unsigned IND_W   = $clog2(MAX_IND + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  input  logic                req_is_store,
  input  logic [IND_W-1:0]    req_ind,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_wmask,
  output logic                stall,
  output logic                done,
  output logic [DATA_W-1:0]   rdata,
  output logic                dmem_read,
  output logic                dmem_write,
  output logic [ADDR_W-1:0]   dmem_addr,
  output logic [DATA_W-1:0]   dmem_wdata,
  output logic [DATA_W/8-1:0] dmem_wmask,
  input  logic                dmem_resp,
  input  logic [DATA_W-1:0]   dmem_rdata
);

  lc3b_memseq_state_t state, state_nx;

  logic                is_store;
  logic [IND_W-1:0]    cnt;
  logic [ADDR_W-1:0]   addr;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wmask;

  logic load, step;
  assign load = (state == S_IDLE) && req_valid;
  assign step = (state == S_PTR) && dmem_resp;

  mem_req_reg #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .MAX_IND(MAX_IND),
    .IND_W  (IND_W)
  ) u_req (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (load),
    .step        (step),
    .req_is_store(req_is_store),
    .req_ind     (req_ind),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_wmask   (req_wmask),
    .next_ptr    (dmem_rdata[ADDR_W-1:1]),
    .is_store    (is_store),
    .cnt         (cnt),
    .addr        (addr),
    .wdata       (wdata),
    .wmask       (wmask)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                            rdata <= '0;
    else if ((state == S_FINAL) && dmem_resp && !is_store) rdata <= dmem_rdata;
  end

  // Clamping never turns a nonzero depth into zero (MAX_IND >= 1), so the
  // raw request decides whether a pointer phase is needed.
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (req_valid) state_nx = (req_ind != '0) ? S_PTR : S_FINAL;
      S_PTR:   if (dmem_resp && (cnt == IND_W'(1))) state_nx = S_FINAL;
      S_FINAL: if (dmem_resp) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    stall      = 1'b0;
    done       = 1'b0;
    dmem_read  = 1'b0;
    dmem_write = 1'b0;
    dmem_addr  = '0;
    dmem_wdata = '0;
    dmem_wmask = '0;
    unique case (state)
      S_IDLE:  stall = req_valid;
      S_PTR: begin
        stall     = 1'b1;
        dmem_read = 1'b1;
        dmem_addr = addr;
      end
      S_FINAL: begin
        stall      = 1'b1;
        dmem_read  = ~is_store;
        dmem_write = is_store;
        dmem_addr  = addr;
        dmem_wdata = wdata;
        dmem_wmask = is_store ? wmask : '0;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_indirect_seq.sv
module tb_mem_indirect_seq;

  localparam int AW = 16;
  localparam int DW = 16;
  localparam int MI = 5;
  localparam int IW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid, req_is_store;
  logic [IW-1:0] req_ind;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [1:0]    req_wmask;
  logic          stall, done, dmem_read, dmem_write, dmem_resp;
  logic [DW-1:0] rdata, dmem_wdata, dmem_rdata;
  logic [AW-1:0] dmem_addr;
  logic [1:0]    dmem_wmask;

  mem_indirect_seq #(.ADDR_W(AW), .DATA_W(DW), .MAX_IND(MI), .IND_W(IW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_is_store(req_is_store),
    .req_ind(req_ind), .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .stall(stall), .done(done), .rdata(rdata), .dmem_read(dmem_read),
    .dmem_write(dmem_write), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_wmask(dmem_wmask), .dmem_resp(dmem_resp), .dmem_rdata(dmem_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural memory: byte-addressed array of words, fixed wait states.
  logic [15:0] mem [0:65535];
  int  nwait = 0;
  int  wcnt  = 0;
  bit  inject = 1'b0;
  int  overlap_err = 0;
  logic strobe;
  assign strobe     = dmem_read | dmem_write;
  assign dmem_resp  = inject | (strobe && (wcnt == nwait));
  assign dmem_rdata = inject ? 16'hDEAD : mem[dmem_addr];

  typedef struct { bit wr; logic [15:0] addr; logic [15:0] data; logic [1:0] mask; } acc_t;
  acc_t log_q[$];
  acc_t exp_q[$];

  always @(posedge clk) begin
    if (strobe && dmem_resp && !inject) begin
      log_q.push_back('{dmem_write, dmem_addr, dmem_write ? dmem_wdata : dmem_rdata, dmem_wmask});
      if (dmem_write)
        mem[dmem_addr] <= {dmem_wmask[1] ? dmem_wdata[15:8] : mem[dmem_addr][15:8],
                           dmem_wmask[0] ? dmem_wdata[7:0]  : mem[dmem_addr][7:0]};
    end
    if (strobe && !dmem_resp) wcnt <= wcnt + 1;
    else                      wcnt <= 0;
  end

  always @(negedge clk) if (dmem_read && dmem_write) overlap_err++;

  int tests  = 0;
  int failed = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: walk the pointer chain in the memory image.
  logic [15:0] exp_rdata;
  logic [15:0] exp_memval;
  logic [15:0] exp_addr;
  bit          exp_store;
  int          exp_lat;

  task automatic model(input bit st, input int ind, input logic [15:0] a,
                       input logic [15:0] wd, input logic [1:0] wm, input int w);
    int n;
    logic [15:0] p;
    n = (ind > MI) ? MI : ind;
    p = a;
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      exp_q.push_back('{1'b0, p, mem[p], 2'b00});
      p = mem[p] & 16'hFFFE;
    end
    exp_store = st;
    exp_addr  = p;
    if (st) begin
      exp_memval = mem[p];
      if (wm[0]) exp_memval[7:0]  = wd[7:0];
      if (wm[1]) exp_memval[15:8] = wd[15:8];
      exp_q.push_back('{1'b1, p, wd, wm});
    end else begin
      exp_rdata = mem[p];
      exp_q.push_back('{1'b0, p, mem[p], 2'b00});
    end
    exp_lat = 1 + (n + 1) * (w + 1);
  endtask

  task automatic drive(input bit st, input int ind, input logic [15:0] a,
                       input logic [15:0] wd, input logic [1:0] wm);
    req_valid    = 1'b1;
    req_is_store = st;
    req_ind      = IW'(ind);
    req_addr     = a;
    req_wdata    = wd;
    req_wmask    = wm;
  endtask

  // Called at the falling edge of the accept cycle (cycle 0).
  task automatic wait_done(input string tag);
    int cyc;
    bit got;
    cyc = 0;
    got = 1'b0;
    #1 check({tag, ".stall0"}, stall, 1);
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      cyc++;
      if (done === 1'b1) begin got = 1'b1; break; end
      check({tag, ".stall"}, stall, 1);
    end
    check({tag, ".done_seen"}, got, 1);
    if (got) begin
      check({tag, ".latency"}, cyc, exp_lat);
      check({tag, ".rdata"}, rdata, exp_rdata);
      check({tag, ".stall_done"}, stall, 0);
      check({tag, ".strobes_done"}, {dmem_read, dmem_write}, 0);
      check({tag, ".n_access"}, log_q.size(), exp_q.size());
      if (log_q.size() == exp_q.size())
        foreach (exp_q[i]) begin
          check({tag, ".acc_wr"},   log_q[i].wr,   exp_q[i].wr);
          check({tag, ".acc_addr"}, log_q[i].addr, exp_q[i].addr);
          check({tag, ".acc_data"}, log_q[i].data, exp_q[i].data);
          check({tag, ".acc_mask"}, log_q[i].mask, exp_q[i].mask);
        end
      if (exp_store) check({tag, ".mem_after_store"}, mem[exp_addr], exp_memval);
    end
    log_q.delete();
  endtask

  task automatic req(input string tag, input bit st, input int ind, input logic [15:0] a,
                     input logic [15:0] wd, input logic [1:0] wm, input int w);
    @(negedge clk);
    nwait = w;
    model(st, ind, a, wd, wm, w);
    drive(st, ind, a, wd, wm);
    wait_done(tag);
    req_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
    rst_n = 1'b0;
    req_valid = 1'b0; req_is_store = 1'b0; req_ind = '0;
    req_addr = '0; req_wdata = '0; req_wmask = '0;
    exp_rdata = '0;
    #1;
    check("rst.stall", stall, 0);
    check("rst.done", done, 0);
    check("rst.strobes", {dmem_read, dmem_write}, 0);
    check("rst.rdata", rdata, 0);
    check("rst.addr", dmem_addr, 0);
    check("rst.wdata_mask", {dmem_wdata, dmem_wmask}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Direct load
    mem[16'h3000] = 16'hBEEF;
    req("ldr", 0, 0, 16'h3000, 16'h0, 2'b00, 0);

    // LDI, odd pointer is word-aligned
    mem[16'h4000] = 16'h5001;
    mem[16'h5000] = 16'h1234;
    req("ldi", 0, 1, 16'h4000, 16'h0, 2'b00, 0);

    // STI with two wait states per access
    mem[16'h4100] = 16'h6000;
    req("sti_wait", 1, 1, 16'h4100, 16'hA55A, 2'b11, 2);

    // Depth-3 chain, then out-of-range depth clamps to MAX_IND
    mem[16'h0100] = 16'h0200;
    mem[16'h0200] = 16'h0300;
    mem[16'h0300] = 16'h0400;
    mem[16'h0400] = 16'h00FF;
    req("chain3", 0, 3, 16'h0100, 16'h0, 2'b00, 0);
    req("clamp7", 0, 7, 16'h0100, 16'h0, 2'b00, 1);

    // Partial byte-masked store
    req("st_lo", 1, 0, 16'h2200, 16'h77CC, 2'b01, 0);

    // Reset in the middle of a pointer read
    @(negedge clk);
    nwait = 3;
    drive(0, 3, 16'h0100, 16'h0, 2'b00);
    repeat (2) @(negedge clk);
    check("midrst.in_ptr", {stall, dmem_read}, 2'b11);
    rst_n = 1'b0;
    req_valid = 1'b0;
    #1;
    exp_rdata = '0;
    check("midrst.stall", stall, 0);
    check("midrst.read", dmem_read, 0);
    check("midrst.done", done, 0);
    check("midrst.rdata", rdata, 0);
    @(negedge clk);
    rst_n = 1'b1;
    log_q.delete();
    @(negedge clk);
    inject = 1'b1;
    @(negedge clk);
    inject = 1'b0;
    check("stray.stall", stall, 0);
    check("stray.done", done, 0);
    check("stray.strobes", {dmem_read, dmem_write}, 0);
    req("post_rst_st", 1, 0, 16'h2000, 16'h1357, 2'b11, 0);

    // Back-to-back direct loads, req_valid never drops
    mem[16'h3100] = 16'h1111;
    mem[16'h3200] = 16'h2222;
    @(negedge clk);
    nwait = 0;
    model(0, 0, 16'h3100, 16'h0, 2'b00, 0);
    drive(0, 0, 16'h3100, 16'h0, 2'b00);
    wait_done("b2b_a");
    model(0, 0, 16'h3200, 16'h0, 2'b00, 0);
    drive(0, 0, 16'h3200, 16'h0, 2'b00);
    @(negedge clk);
    wait_done("b2b_b");
    req_valid = 1'b0;

    // Randomized requests
    for (int r = 0; r < 30; r++) begin
      bit st;
      int ind, w;
      logic [15:0] a, wd;
      logic [1:0] wm;
      st  = 1'($urandom_range(0, 1));
      ind = $urandom_range(0, 7);
      w   = $urandom_range(0, 2);
      a   = 16'($urandom) & 16'hFFFE;
      wd  = 16'($urandom);
      wm  = 2'($urandom);
      req("rand", st, ind, a, wd, wm, w);
    end

    check("strobe_overlap", overlap_err, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
